multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Control FSM that sequences the multi-cycle variant of the team's MIPS CPU datapath (PC, IR, register file, ALU, sign-extend, ALU-source and PC-source muxes, shared instruction/data memory). It takes the latched opcode and the ALU zero flag and drives the datapath's write strobes, mux selects and ALU operation for each phase. It stalls on a memory ready handshake, counts retired instructions, and traps on illegal opcodes.

## Interface
Parameters:
- none; opcode set and state encoding below are fixed.

Ports (clock and reset first):
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- opcode_i  in  6  instr[31:26] from IR; valid from DECODE onward.
- zero_i  in  1  ALU zero flag, same cycle.
- mem_ready_i  in  1  memory completes the current access this cycle.
- mem_req_o  out  1  memory access request.
- mem_we_o  out  1  memory write (with mem_req_o).
- iord_o  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_we_o  out  1  IR load.
- pc_we_o  out  1  PC load.
- pc_src_o  out  2  PC input select: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- alu_src_a_o  out  1  0 = PC, 1 = reg A.
- alu_src_b_o  out  2  00 = reg B, 01 = const 4, 10 = ext imm, 11 = ext imm<<2.
- alu_op_o  out  3  000 = add, 001 = sub, 010 = funct-decoded, 011 = slt, 100 = or, 101 = lui.
- sign_ext_o  out  1  1 = sign-extend, 0 = zero-extend.
- reg_dst_o  out  1  0 = rt, 1 = rd.
- mem_to_reg_o  out  1  1 = write-back from MDR.
- reg_we_o  out  1  register file write.
- state_o  out  4  current state encoding.
- retired_o  out  32  retired-instruction count.
- trap_o  out  1  sticky illegal-opcode flag.

## Operation
- Opcodes: R = 0x00, j = 0x02, beq = 0x04, bne = 0x05, addi = 0x08, slti = 0x0A, ori = 0x0D, lui = 0x0F, lw = 0x23, sw = 0x2B. Any other opcode is illegal.
- States: FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5, R_EXEC = 6, R_WB = 7, BRANCH = 8, I_EXEC = 9, I_WB = 10, JUMP = 11, TRAP = 12. Encodings 13–15 go to TRAP.
- Defaults in every state: all strobes 0, selects 0, alu_op = add, sign_ext = 1.
- FETCH:
  - Drives mem_req = 1, iord = 0, src_a = 0, src_b = 01, pc_src = 00.
  - If mem_ready: ir_we = 1, pc_we = 1, go to DECODE. Otherwise hold in FETCH.
- DECODE:
  - Drives src_a = 0, src_b = 11, add (branch target into ALUOut).
  - Next state: lw/sw → MEM_ADDR; R → R_EXEC; beq/bne → BRANCH; addi/slti/ori/lui → I_EXEC; j → JUMP; illegal → TRAP.
- MEM_ADDR: src_a = 1, src_b = 10, add. Go to MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_req = 1, iord = 1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_we = 1, reg_dst = 0, mem_to_reg = 1. Go to FETCH.
- MEM_WRITE: mem_req = 1, mem_we = 1, iord = 1. Hold until mem_ready, then go to FETCH.
- R_EXEC: src_a = 1, src_b = 00, alu_op = 010. Go to R_WB.
- R_WB: reg_we = 1, reg_dst = 1. Go to FETCH.
- BRANCH:
  - Drives src_a = 1, src_b = 00, sub, pc_src = 01.
  - pc_we = zero_i for beq, ~zero_i for bne. Go to FETCH.
- I_EXEC:
  - Drives src_a = 1, src_b = 10.
  - alu_op: addi → 000, slti → 011, ori → 100, lui → 101. sign_ext = 0 for ori only.
  - Go to I_WB.
- I_WB: reg_we = 1, reg_dst = 0, mem_to_reg = 0. Go to FETCH.
- JUMP: pc_src = 10, pc_we = 1. Go to FETCH.
- TRAP: all strobes 0, trap_o = 1. Stays in TRAP until reset.
- Retire: retired_o increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH (taken or not), I_WB or JUMP. It wraps from 0xFFFFFFFF to 0.

## Timing
- State, retired_o and trap_o are registers. All other outputs are combinational from state, opcode_i, zero_i and mem_ready_i.
- Reset:
  - While rst_i = 1, mem_req, mem_we, ir_we, pc_we and reg_we are forced to 0.
  - At the edge: state = FETCH, retired_o = 0, trap_o = 0.
  - The first fetch request appears the first cycle rst_i = 0.
- Reset mid-access (in MEM_READ, MEM_WRITE or FETCH waiting) abandons the access; no strobe fires in the reset cycle.
- Latency with zero wait states (mem_ready_i tied 1): j, beq and bne take 3 cycles; R, I-type and sw take 4; lw takes 5.
- Each cycle with mem_ready_i = 0 in a memory state adds 1 cycle. Nothing else changes while waiting.
- mem_ready_i is ignored outside FETCH, MEM_READ and MEM_WRITE.
- Illegal opcode: TRAP is entered on the cycle after DECODE. trap_o rises that cycle. No retire.

## Test plan
- Reset, then mem_ready = 1: the cycle after release shows state_o = 0, mem_req_o = 1, pc_we_o = 1, ir_we_o = 1, retired_o = 0.
- Fetch 0x23 (lw) with 2 wait cycles in MEM_READ: state sequence 0,1,2,3,3,3,4,0; reg_we_o = 1 and mem_to_reg_o = 1 only in state 4; retired_o = 1.
- beq (0x04) with zero_i = 1 → pc_we_o = 1, pc_src_o = 01 in BRANCH. bne (0x05) with zero_i = 1 → pc_we_o = 0. Both increment retired_o.
- ori (0x0D): in I_EXEC, alu_op_o = 100 and sign_ext_o = 0. Then I_WB has reg_we_o = 1, reg_dst_o = 0. Total 4 cycles.
- Opcode 0x3F: state goes 0,1,12; trap_o = 1 and stays; no strobes for 20 cycles; rst_i clears trap_o.
- Preload retired_o to 0xFFFFFFFF via a run plus forced value, retire a j (0x02) → retired_o = 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: phase sequencer for the multi-cycle MIPS datapath.
// Drives write strobes, mux selects and ALU op for each phase. It stalls
// on the memory ready handshake, counts retired instructions and traps
// on illegal opcodes.
module multicycle_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  opcode_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        iord_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_src_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [2:0]  alu_op_o,
    output logic        sign_ext_o,
    output logic        reg_dst_o,
    output logic        mem_to_reg_o,
    output logic        reg_we_o,
    output logic [3:0]  state_o,
    output logic [31:0] retired_o,
    output logic        trap_o
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_R_EXEC    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_I_EXEC    = 4'd9;
    localparam logic [3:0] S_I_WB      = 4'd10;
    localparam logic [3:0] S_JUMP      = 4'd11;
    localparam logic [3:0] S_TRAP      = 4'd12;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_SLT   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_LUI   = 3'b101;

    logic [3:0]  state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        trap_q, trap_d;
    logic        retire;

    // Strobes before reset gating; reset must suppress every write.
    logic mem_req, mem_we, ir_we, pc_we, reg_we;

    // Per-phase control decode and next-state selection.
    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        reg_we       = 1'b0;
        iord_o       = 1'b0;
        pc_src_o     = 2'b00;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = ALU_ADD;
        sign_ext_o   = 1'b1;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req     = 1'b1;
                alu_src_b_o = 2'b01;
                if (mem_ready_i) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // PC + (imm<<2) lands in ALUOut for a possible branch.
                alu_src_b_o = 2'b11;
                case (opcode_i)
                    OP_LW, OP_SW:                       state_d = S_MEM_ADDR;
                    OP_R:                               state_d = S_R_EXEC;
                    OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ORI, OP_LUI:   state_d = S_I_EXEC;
                    OP_J:                               state_d = S_JUMP;
                    default:                            state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d     = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                iord_o  = 1'b1;
                if (mem_ready_i) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_we       = 1'b1;
                mem_to_reg_o = 1'b1;
                state_d      = S_FETCH;
                retire       = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord_o  = 1'b1;
                if (mem_ready_i) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_FUNCT;
                state_d     = S_R_WB;
            end
            S_R_WB: begin
                reg_we    = 1'b1;
                reg_dst_o = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_SUB;
                pc_src_o    = 2'b01;
                pc_we       = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
                state_d     = S_FETCH;
                retire      = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                case (opcode_i)
                    OP_SLTI: alu_op_o = ALU_SLT;
                    OP_ORI: begin
                        alu_op_o   = ALU_OR;
                        sign_ext_o = 1'b0;
                    end
                    OP_LUI:  alu_op_o = ALU_LUI;
                    default: alu_op_o = ALU_ADD;
                endcase
                state_d = S_I_WB;
            end
            S_I_WB: begin
                reg_we  = 1'b1;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_JUMP: begin
                pc_src_o = 2'b10;
                pc_we    = 1'b1;
                state_d  = S_FETCH;
                retire   = 1'b1;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // Retire counter wraps naturally; trap is sticky once TRAP is reached.
    always_comb begin
        retired_d = retired_q + 32'd1;
        trap_d    = trap_q | (state_d == S_TRAP);
    end

    // State, retire count and trap flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            retired_q <= 32'd0;
            trap_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_d;
            if (retire) retired_q <= retired_d;
        end
    end

    assign mem_req_o = mem_req & ~rst_i;
    assign mem_we_o  = mem_we  & ~rst_i;
    assign ir_we_o   = ir_we   & ~rst_i;
    assign pc_we_o   = pc_we   & ~rst_i;
    assign reg_we_o  = reg_we  & ~rst_i;
    assign state_o   = state_q;
    assign retired_o = retired_q;
    assign trap_o    = trap_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level reference model built from
// per-opcode phase paths, driven with random opcodes, branch flags and
// memory wait states, plus directed reset, trap and wrap scenarios.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_i, zero_i, mem_ready_i;
    logic [5:0]  opcode_i;
    logic        mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o;
    logic [1:0]  pc_src_o, alu_src_b_o;
    logic        alu_src_a_o, sign_ext_o, reg_dst_o, mem_to_reg_o, reg_we_o;
    logic [2:0]  alu_op_o;
    logic [3:0]  state_o;
    logic [31:0] retired_o;
    logic        trap_o;

    multicycle_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .iord_o(iord_o), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .pc_src_o(pc_src_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
        .sign_ext_o(sign_ext_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
        .reg_we_o(reg_we_o), .state_o(state_o), .retired_o(retired_o), .trap_o(trap_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ret;
    int          path[6];
    int          plen;
    logic [5:0]  legal_ops[10] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08,
                                   6'h0A, 6'h0D, 6'h0F, 6'h23, 6'h2B};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] dut_ctrl();
        return {mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, pc_src_o, alu_src_a_o,
                alu_src_b_o, alu_op_o, sign_ext_o, reg_dst_o, mem_to_reg_o, reg_we_o};
    endfunction

    // Expected controls for one phase, taken from the phase descriptions.
    function automatic logic [16:0] exp_ctrl(input int st, input logic [5:0] op,
                                             input logic z, input logic r);
        logic       mreq = 0, mwe = 0, io = 0, irwe = 0, pcwe = 0, sa = 0;
        logic       se = 1, rd = 0, m2r = 0, rwe = 0;
        logic [1:0] pcs = 0, sb = 0;
        logic [2:0] aop = 0;
        case (st)
            0:  begin mreq = 1; sb = 2'b01; irwe = r; pcwe = r; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mreq = 1; io = 1; end
            4:  begin rwe = 1; m2r = 1; end
            5:  begin mreq = 1; mwe = 1; io = 1; end
            6:  begin sa = 1; aop = 3'b010; end
            7:  begin rwe = 1; rd = 1; end
            8:  begin sa = 1; aop = 3'b001; pcs = 2'b01; pcwe = (op == 6'h04) ? z : !z; end
            9:  begin
                    sa = 1; sb = 2'b10;
                    if (op == 6'h0A) aop = 3'b011;
                    if (op == 6'h0D) begin aop = 3'b100; se = 0; end
                    if (op == 6'h0F) aop = 3'b101;
                end
            10: rwe = 1;
            11: begin pcs = 2'b10; pcwe = 1; end
            default: ;
        endcase
        return {mreq, mwe, io, irwe, pcwe, pcs, sa, sb, aop, se, rd, m2r, rwe};
    endfunction

    // Phase path of one instruction, from fetch to its last phase.
    function automatic void set_path(input logic [5:0] op);
        path[0] = 0; path[1] = 1;
        case (op)
            6'h23:                      begin path[2] = 2; path[3] = 3; path[4] = 4; plen = 5; end
            6'h2B:                      begin path[2] = 2; path[3] = 5; plen = 4; end
            6'h00:                      begin path[2] = 6; path[3] = 7; plen = 4; end
            6'h04, 6'h05:               begin path[2] = 8; plen = 3; end
            6'h08, 6'h0A, 6'h0D, 6'h0F: begin path[2] = 9; path[3] = 10; plen = 4; end
            6'h02:                      begin path[2] = 11; plen = 3; end
            default:                    begin path[2] = 12; plen = 3; end
        endcase
    endfunction

    // Called at a negedge with the DUT in FETCH. mode: 0 = always ready,
    // 1 = random ready, 2 = two wait cycles in MEM_READ.
    task automatic run_instr(input logic [5:0] op, input logic z, input int mode);
        int idx = 0, cyc = 0, wcnt = 0, cur;
        logic r;
        set_path(op);
        while (idx < plen && cyc < 200) begin
            cur = path[idx];
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 2) != 0);
                default: r = (cur == 3) ? (wcnt >= 2) : 1'b1;
            endcase
            if (cur == 3) wcnt++;
            opcode_i    = (cur == 0) ? 6'($urandom) : op;
            zero_i      = z;
            mem_ready_i = r;
            #1;
            chk($sformatf("state op%h c%0d", op, cyc), 32'(state_o), 32'(cur));
            chk($sformatf("ctrl op%h s%0d", op, cur), 32'(dut_ctrl()),
                32'(exp_ctrl(cur, op, z, r)));
            chk($sformatf("trap op%h s%0d", op, cur), 32'(trap_o), 32'(cur == 12));
            if (!((cur == 0 || cur == 3 || cur == 5) && !r)) idx++;
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 200) chk("cycle budget", 32'(cyc), 32'd0);
        if (path[plen-1] != 12) exp_ret = exp_ret + 32'd1;
        #1;
        chk($sformatf("retired op%h", op), retired_o, exp_ret);
        chk($sformatf("next state op%h", op), 32'(state_o), (path[plen-1] == 12) ? 32'd12 : 32'd0);
    endtask

    // Reset is asserted for one cycle with ready high; strobes must stay low.
    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1; mem_ready_i = 1'b1; zero_i = 1'b1; opcode_i = 6'h23;
        #1;
        chk("strobes in reset", 32'({mem_req_o, mem_we_o, ir_we_o, pc_we_o, reg_we_o}), 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        exp_ret = 32'd0;
        #1;
        chk("reset state", 32'(state_o), 32'd0);
        chk("reset retired", retired_o, 32'd0);
        chk("reset trap", 32'(trap_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; opcode_i = 6'h00; zero_i = 1'b0; mem_ready_i = 1'b0;
        exp_ret = 32'd0;
        @(negedge clk);
        do_reset();

        // Directed: first fetch, lw with two read waits, branches, ori.
        run_instr(6'h23, 1'b0, 2);
        run_instr(6'h04, 1'b1, 0);
        run_instr(6'h05, 1'b1, 0);
        run_instr(6'h04, 1'b0, 0);
        run_instr(6'h05, 1'b0, 0);
        run_instr(6'h0D, 1'b0, 0);
        run_instr(6'h2B, 1'b0, 1);

        // Random instruction stream with random wait states.
        for (int n = 0; n < 60; n++)
            run_instr(legal_ops[$urandom_range(0, 9)], 1'($urandom), 1);

        // Reset in the middle of a load read abandons it.
        do_reset();
        run_instr(6'h00, 1'b0, 0);
        opcode_i = 6'h23; mem_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("abandon path", 32'(state_o), 32'(i));
            @(negedge clk);
        end
        #1 chk("abandon in read", 32'(state_o), 32'd3);
        do_reset();

        // Illegal opcode: trap, sticky, no strobes, cleared by reset.
        run_instr(6'h3F, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            opcode_i = 6'($urandom); zero_i = 1'($urandom); mem_ready_i = 1'($urandom);
            #1;
            chk("trap hold state", 32'(state_o), 32'd12);
            chk("trap sticky", 32'(trap_o), 32'd1);
            chk("trap strobes", 32'({mem_req_o, mem_we_o, ir_we_o, pc_we_o, reg_we_o}), 32'd0);
            chk("trap retired", retired_o, 32'd0);
            @(negedge clk);
        end
        do_reset();

        // Retire counter wrap: preload all-ones while a jump is in flight.
        opcode_i = 6'h02; mem_ready_i = 1'b1;
        #1 chk("wrap fetch", 32'(state_o), 32'd0);
        @(negedge clk);
        #1 chk("wrap decode", 32'(state_o), 32'd1);
        force dut.retired_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retired_q;
        #1;
        chk("wrap jump", 32'(state_o), 32'd11);
        chk("wrap preload", retired_o, 32'hFFFF_FFFF);
        chk("wrap jump ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(11, 6'h02, 1'b0, 1'b1)));
        @(negedge clk);
        #1;
        chk("wrap retired", retired_o, 32'd0);
        chk("wrap back to fetch", 32'(state_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
